prog_loader: RTL and testbench

// Byte-stream program loader: the writer side of the CPU's instruction-fetch path. Takes a framed

---
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader. Parses a framed stream (length, payload,
// checksum), writes the payload into program RAM starting at address 0,
// keeps the CPU halted while loading and pulses cpu_run after a good load.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              cpu_hold,
  output logic              cpu_run,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_reg, state_next;

  // Index of the final payload byte (N-1); N=0 wraps to all ones, i.e. a full RAM.
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] addr_cnt_reg;
  logic [DATA_W-1:0] sum_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_data_reg;
  logic              mem_wren_reg;
  logic              hold_reg;
  logic              err_reg;

  logic              accept;
  logic              start_ok;
  logic              last_byte;
  logic              csum_good;

  // abort wins over both a byte handshake and a start request
  assign accept    = in_valid && in_ready && !abort;
  assign start_ok  = (state_reg == S_IDLE) && start && !abort;
  assign last_byte = (addr_cnt_reg == last_reg);
  assign csum_good = (in_data == sum_reg);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (start) state_next = S_LEN;
        S_LEN:  if (in_valid) state_next = S_DATA;
        S_DATA: if (in_valid && last_byte) state_next = S_CSUM;
        S_CSUM: if (in_valid) state_next = csum_good ? S_DONE : S_ERR;
        S_DONE: state_next = S_IDLE;
        S_ERR:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs; the RAM bus stays claimed until a pending write lands
  always_comb begin
    busy     = (state_reg == S_LEN) || (state_reg == S_DATA) || (state_reg == S_CSUM);
    in_ready = busy;
    cpu_run  = (state_reg == S_DONE);
    mem_sel  = busy || mem_wren_reg;
  end

  // Datapath: length capture, write pipeline, running checksum, hold and error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_reg     <= '0;
      addr_cnt_reg <= '0;
      sum_reg      <= '0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
      mem_wren_reg <= 1'b0;
      hold_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      mem_wren_reg <= 1'b0;
      if (start_ok) begin
        addr_cnt_reg <= '0;
        sum_reg      <= '0;
        err_reg      <= 1'b0;
        hold_reg     <= 1'b1;
      end
      if (abort) begin
        hold_reg <= 1'b0;
      end
      if (accept) begin
        case (state_reg)
          S_LEN: begin
            last_reg <= ADDR_W'(in_data) - ADDR_W'(1);
          end
          S_DATA: begin
            mem_addr_reg <= addr_cnt_reg;
            mem_data_reg <= in_data;
            mem_wren_reg <= 1'b1;
            addr_cnt_reg <= addr_cnt_reg + ADDR_W'(1);
            sum_reg      <= sum_reg + in_data;
          end
          S_CSUM: begin
            // a good load releases the CPU; a bad one keeps it halted
            if (csum_good) begin
              hold_reg <= 1'b0;
            end else begin
              err_reg <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign mem_addr = mem_addr_reg;
  assign mem_data = mem_data_reg;
  assign mem_wren = mem_wren_reg;
  assign cpu_hold = hold_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized
// frames checked against a frame-level model (expected write list,
// checksum verdict, hold/err/run outcome).
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic              cpu_hold;
  logic              cpu_run;
  logic              busy;
  logic              err;

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wren(mem_wren), .cpu_hold(cpu_hold), .cpu_run(cpu_run),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miscompare_cnt = 0;
  int run_cnt = 0;
  logic [15:0] wr_q[$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe the RAM port and the run pulse on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      if (mem_wren) begin
        wr_q.push_back({mem_addr, mem_data});
        check_value("mem_sel_during_wren", 32'(mem_sel), 32'd1);
      end
      if (cpu_run) begin
        run_cnt++;
        check_value("hold_low_at_run", 32'(cpu_hold), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte, optionally preceded by idle gaps and with a stray start
  task automatic drive_byte(input logic [7:0] b, input int gap_pct, input bit noise);
    while (int'($urandom_range(0, 99)) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    check_value("in_ready_byte", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_value("hold_after_start", 32'(cpu_hold), 32'd1);
    check_value("err_after_start", 32'(err), 32'd0);
    check_value("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Full frame against the model: payload lands at 0..n-1, verdict from the sum
  task automatic run_frame(input logic [7:0] payload[$], input bit use_csum,
                           input logic [7:0] csum_in, input int gap_pct, input bit noise);
    logic [7:0] sum;
    logic [7:0] csum;
    bit         bad;
    int         n;
    int         runs_before;
    n   = payload.size();
    sum = 8'h00;
    foreach (payload[i]) sum = sum + payload[i];
    csum = use_csum ? csum_in : sum;
    bad  = (csum != sum);
    wr_q.delete();
    runs_before = run_cnt;
    start_frame();
    drive_byte(8'(n), gap_pct, 1'b0);
    foreach (payload[i]) drive_byte(payload[i], gap_pct, noise);
    drive_byte(csum, gap_pct, 1'b0);
    repeat (3) tick();
    check_value("write_count", 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      check_value("write_addr", 32'(wr_q[i][15:8]), 32'(i % 256));
      check_value("write_data", 32'(wr_q[i][7:0]), 32'(payload[i]));
    end
    check_value("run_pulses", 32'(run_cnt - runs_before), bad ? 32'd0 : 32'd1);
    check_value("err_after_frame", 32'(err), 32'(bad));
    check_value("hold_after_frame", 32'(cpu_hold), 32'(bad));
    check_value("busy_after_frame", 32'(busy), 32'd0);
    check_value("mem_sel_after_frame", 32'(mem_sel), 32'd0);
    $display("frame n=%0d csum=%02h bad=%0d writes=%0d runs=%0d", n, csum, bad,
             wr_q.size(), run_cnt - runs_before);
  endtask

  // Bytes offered while idle must not be consumed or written
  task automatic idle_junk(input bit exp_hold);
    wr_q.delete();
    in_valid = 1'b1;
    repeat (3) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check_value("idle_no_writes", 32'(wr_q.size()), 32'd0);
    check_value("idle_in_ready", 32'(in_ready), 32'd0);
    check_value("idle_hold", 32'(cpu_hold), 32'(exp_hold));
  endtask

  initial begin
    logic [7:0] pl[$];
    int         runs_before;

    // reset state
    #1;
    check_value("rst_in_ready", 32'(in_ready), 32'd0);
    check_value("rst_mem_sel", 32'(mem_sel), 32'd0);
    check_value("rst_wren", 32'(mem_wren), 32'd0);
    check_value("rst_hold", 32'(cpu_hold), 32'd0);
    check_value("rst_run", 32'(cpu_run), 32'd0);
    check_value("rst_err", 32'(err), 32'd0);
    check_value("rst_addr", 32'(mem_addr), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // basic load
    pl = '{8'h11, 8'h22, 8'h33};
    run_frame(pl, 1'b1, 8'h66, 0, 1'b0);

    // bad checksum keeps the CPU halted across idle cycles
    pl = '{8'h01, 8'h02};
    run_frame(pl, 1'b1, 8'h04, 0, 1'b0);
    idle_junk(1'b1);

    // full wrap: 256 bytes of ramp
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    run_frame(pl, 1'b1, 8'h80, 0, 1'b0);
    idle_junk(1'b0);

    // gaps in in_valid
    pl = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h99, 8'h01};
    run_frame(pl, 1'b0, 8'h00, 50, 1'b0);

    // abort after 2 of 5 bytes, with a byte offered in the abort cycle
    wr_q.delete();
    runs_before = run_cnt;
    start_frame();
    drive_byte(8'd5, 0, 1'b0);
    drive_byte(8'h10, 0, 1'b0);
    drive_byte(8'h20, 0, 1'b0);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check_value("abort_in_ready", 32'(in_ready), 32'd0);
    check_value("abort_hold", 32'(cpu_hold), 32'd0);
    check_value("abort_err", 32'(err), 32'd0);
    idle_junk(1'b0);
    check_value("abort_writes", 32'(wr_q.size()), 32'd0);
    check_value("abort_runs", 32'(run_cnt - runs_before), 32'd0);
    $display("abort after 2 bytes done");
    pl = '{8'h07, 8'h08, 8'h09};
    run_frame(pl, 1'b0, 8'h00, 0, 1'b0);

    // asynchronous reset mid-DATA
    start_frame();
    drive_byte(8'd10, 0, 1'b0);
    repeat (3) drive_byte(8'($urandom), 0, 1'b0);
    check_value("wren_before_reset", 32'(mem_wren), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_value("arst_in_ready", 32'(in_ready), 32'd0);
    check_value("arst_mem_sel", 32'(mem_sel), 32'd0);
    check_value("arst_wren", 32'(mem_wren), 32'd0);
    check_value("arst_hold", 32'(cpu_hold), 32'd0);
    check_value("arst_busy", 32'(busy), 32'd0);
    check_value("arst_addr", 32'(mem_addr), 32'd0);
    check_value("arst_data", 32'(mem_data), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    $display("async reset mid-frame done");
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(pl, 1'b0, 8'h00, 0, 1'b0);

    // randomized frames: random length, payload, gaps, stray starts, bad checksums
    for (int f = 0; f < 25; f++) begin
      int n;
      n = int'($urandom_range(1, 20));
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      run_frame(pl, ($urandom_range(0, 2) == 0), 8'($urandom),
                int'($urandom_range(0, 60)), 1'b1);
      if ($urandom_range(0, 3) == 0) idle_junk(cpu_hold);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
